// File: rtl/inverse_pkg.sv
// Shared types, state encoding and phase-boundary helpers for the SPD inverse sequencer.
package inverse_pkg;

  localparam int DEF_N = 6;
  localparam int DEF_W = 36;

  typedef logic signed [DEF_W-1:0] elem_t;
  typedef elem_t [DEF_N-1:0][DEF_N-1:0] mat_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_MMULT = 2'd2
  } state_t;

  // Count at which L^-1 is complete and the multiplier operands are loaded.
  function automatic int load_at(input int chol_cycles, input int ltinv_cycles);
    return chol_cycles + ltinv_cycles;
  endfunction

  // Count at which the multiplier result is valid and captured.
  function automatic int cap_at(input int chol_cycles, input int ltinv_cycles, input int mmult_lat);
    return load_at(chol_cycles, ltinv_cycles) + mmult_lat;
  endfunction

endpackage

// File: rtl/inverse_seq_if.sv
// Host-side start/done handshake and matrix in/out bus of the inverse sequencer.
interface inverse_seq_if #(
  parameter int N = 6,
  parameter int W = 36
);

  logic             en;
  logic             start;
  logic             ready;
  logic             done;
  logic             err;
  logic [N*N*W-1:0] matrix;
  logic [N*N*W-1:0] inverse;

  modport master (
    output en, start, matrix,
    input  ready, done, err, inverse
  );

  modport slave (
    input  en, start, matrix,
    output ready, done, err, inverse
  );

endinterface

// File: rtl/mat_transpose.sv
// Combinational N x N transpose; element [i][j] lives at bits (i*N+j)*W +: W.
module mat_transpose #(
  parameter int N = 6,
  parameter int W = 36
) (
  input  logic [N*N*W-1:0] i_mat,
  output logic [N*N*W-1:0] o_mat
);

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign o_mat[(gi*N+gj)*W +: W] = i_mat[(gj*N+gi)*W +: W];
    end
  end

endmodule

// File: rtl/inverse_seq.sv
// Phase sequencer for A^-1 = L^-T * L^-1: drives the count, loads and captures the matrix multiplier.
// Optional singularity abort on the Cholesky diagonal is enabled by defining INVERSE_SINGULAR_CHECK_EN.
module inverse_seq
  import inverse_pkg::*;
#(
  parameter int N            = 6,
  parameter int W            = 36,
  parameter int CHOL_CYCLES  = 108,
  parameter int LTINV_CYCLES = 107,
  parameter int MMULT_LAT    = 12,
  parameter int CW           = $clog2(CHOL_CYCLES + LTINV_CYCLES + MMULT_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  inverse_seq_if.slave     host,
  output logic [CW-1:0]    o_count,
  output logic [N*N*W-1:0] o_matrix_q,
  input  logic [N*N*W-1:0] i_lt,
  input  logic [N*N*W-1:0] i_lt_inverse,
  input  logic [N*W-1:0]   i_chol_mult_a,
  input  logic [N*W-1:0]   i_chol_mult_b,
  input  logic [N*W-1:0]   i_ltinv_mult_a,
  input  logic [N*W-1:0]   i_ltinv_mult_b,
  output logic [N*W-1:0]   o_array_mult_dataa,
  output logic [N*W-1:0]   o_array_mult_datab,
  output logic [N*N*W-1:0] o_mat_mult_dataa,
  output logic [N*N*W-1:0] o_mat_mult_datab,
  input  logic [N*N*W-1:0] i_mat_mult_result
);

  localparam logic [CW-1:0] LOAD_C = CW'(load_at(CHOL_CYCLES, LTINV_CYCLES));
  localparam logic [CW-1:0] CAP_C  = CW'(cap_at(CHOL_CYCLES, LTINV_CYCLES, MMULT_LAT));
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_ready;
  logic             r_done;
  logic [N*N*W-1:0] r_matrix_q;
  logic [N*N*W-1:0] r_mm_a;
  logic [N*N*W-1:0] r_mm_b;
  logic [N*N*W-1:0] r_inverse;
  logic [N*N*W-1:0] w_lt_inv_t;

  mat_transpose #(
    .N (N),
    .W (W)
  ) u_transpose (
    .i_mat (i_lt_inverse),
    .o_mat (w_lt_inv_t)
  );

  // The two sub-blocks use the shared multiplier in disjoint phases, so OR-merging is lossless.
  assign o_array_mult_dataa = i_chol_mult_a | i_ltinv_mult_a;
  assign o_array_mult_datab = i_chol_mult_b | i_ltinv_mult_b;

`ifdef INVERSE_SINGULAR_CHECK_EN
  localparam logic [CW-1:0] CHOL_C = CW'(CHOL_CYCLES);

  logic r_err;
  logic w_singular;

  // A valid Cholesky factor of an SPD matrix has a strictly positive diagonal.
  function automatic logic diag_bad(input logic [N*N*W-1:0] m);
    logic       bad;
    logic [W-1:0] e;
    bad = 1'b0;
    for (int k = 0; k < N; k++) begin
      e = m[(k*N+k)*W +: W];
      if ((e == '0) || e[W-1]) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  assign w_singular = diag_bad(i_lt);
  assign host.err   = r_err & host.en;
`else
  logic w_unused_lt;

  assign w_unused_lt = ^i_lt;
  assign host.err    = 1'b0;
`endif

  // Sequencer FSM: phase count, operand load, result capture and done pulse; everything holds while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_matrix_q <= '0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_inverse  <= '0;
`ifdef INVERSE_SINGULAR_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else if (host.en) begin
      r_done <= 1'b0;
`ifdef INVERSE_SINGULAR_CHECK_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (host.start) begin
            r_matrix_q <= host.matrix;
            r_state    <= S_RUN;
            r_ready    <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_count == LOAD_C) begin
            r_mm_a  <= w_lt_inv_t;
            r_mm_b  <= i_lt_inverse;
            r_state <= S_MMULT;
            r_count <= r_count + ONE_C;
          end
`ifdef INVERSE_SINGULAR_CHECK_EN
          else if ((r_count == CHOL_C) && w_singular) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_count <= '0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
`endif
          else begin
            r_count <= r_count + ONE_C;
          end
        end
        S_MMULT: begin
          if (r_count == CAP_C) begin
            r_inverse <= i_mat_mult_result;
            r_mm_a    <= '0;
            r_mm_b    <= '0;
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_count   <= '0;
            r_done    <= 1'b1;
          end else begin
            r_count <= r_count + ONE_C;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_count <= '0;
          r_mm_a  <= '0;
          r_mm_b  <= '0;
        end
      endcase
    end
  end

  // A pending done pulse is only shown in an advancing cycle so a stall defers it.
  assign host.done    = r_done & host.en;
  assign host.ready   = r_ready;
  assign host.inverse = r_inverse;

  assign o_count          = r_count;
  assign o_matrix_q       = r_matrix_q;
  assign o_mat_mult_dataa = r_mm_a;
  assign o_mat_mult_datab = r_mm_b;

endmodule

// File: tb/tb_inverse_seq.sv
// Directed bench for inverse_seq at default parameters: latency, load, stall, back-to-back, reset, abort.
module tb_inverse_seq;

  localparam int N  = 6;
  localparam int W  = 36;
  localparam int CW = 8;
  localparam int MW = N*N*W;
  localparam int VW = N*W;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count;
  logic [MW-1:0] matrix_q, lt, lt_inv, mm_a, mm_b, mm_res;
  logic [VW-1:0] ca, cb, la, lb, aa, ab;
  logic [MW-1:0] m1, m2, exp_a, exp_b, all5, all9;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int seen;

  always #5 clk = ~clk;

  inverse_seq_if #(.N(N), .W(W)) host ();

  inverse_seq dut (
    .clk                (clk),
    .rst                (rst),
    .host               (host),
    .o_count            (count),
    .o_matrix_q         (matrix_q),
    .i_lt               (lt),
    .i_lt_inverse       (lt_inv),
    .i_chol_mult_a      (ca),
    .i_chol_mult_b      (cb),
    .i_ltinv_mult_a     (la),
    .i_ltinv_mult_b     (lb),
    .o_array_mult_dataa (aa),
    .o_array_mult_datab (ab),
    .o_mat_mult_dataa   (mm_a),
    .o_mat_mult_datab   (mm_b),
    .i_mat_mult_result  (mm_res)
  );

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic accept();
    host.start = 1'b1;
    tick();
    host.start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    while ((host.done !== 1'b1) && ((cyc - acc_cyc) < budget)) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; host.en = 1'b1; host.start = 1'b0; host.matrix = '0;
    lt = '0; lt_inv = '0; mm_res = '0; ca = '0; cb = '0; la = '0; lb = '0;
    all5 = {36{36'h5}};
    all9 = {36{36'h9}};
    m2   = {36{36'hABC}};
    m1   = '0;
    for (int k = 0; k < N*N; k++) m1[k*W +: W] = W'(k + 1);
    tick(); tick();
    chk("rst_count", MW'(count), MW'(0));
    chk("rst_ready", MW'(host.ready), MW'(1));
    chk("rst_done", MW'(host.done), MW'(0));
    chk("rst_err", MW'(host.err), MW'(0));
    chk("rst_matrix_q", matrix_q, '0);
    chk("rst_mm_a", mm_a, '0);
    chk("rst_mm_b", mm_b, '0);
    chk("rst_inverse", host.inverse, '0);
    rst = 1'b0;

    // shared multiplier operand merge
    ca[35:0] = 36'h123; la[71:36] = 36'h456; cb[107:72] = 36'hA; lb[107:72] = 36'h5;
    #1;
    chk("amul_a", MW'(aa), MW'({36'h456, 36'h123}));
    chk("amul_b", MW'(ab), MW'({36'hF, 72'h0}));

    // normal run: unit lower-inverse with [1][0]=7, result stub all 5
    for (int k = 0; k < N; k++) begin
      lt[(k*N+k)*W +: W]     = 36'h1;
      lt_inv[(k*N+k)*W +: W] = 36'h1;
    end
    lt_inv[216 +: 36] = 36'h7;
    exp_a = '0; exp_b = '0;
    for (int k = 0; k < N; k++) begin
      exp_a[(k*N+k)*W +: W] = 36'h1;
      exp_b[(k*N+k)*W +: W] = 36'h1;
    end
    exp_a[36 +: 36]  = 36'h7;
    exp_b[216 +: 36] = 36'h7;
    mm_res = all5;
    host.matrix = m1;
    accept();
    chk("acc_ready", MW'(host.ready), MW'(0));
    chk("acc_count", MW'(count), MW'(0));
    chk("acc_matrix_q", matrix_q, m1);
    repeat (215) tick();
    chk("c215_count", MW'(count), MW'(215));
    chk("c215_mm_a", mm_a, '0);
    tick();
    chk("load_count", MW'(count), MW'(216));
    chk("load_mm_a", mm_a, exp_a);
    chk("load_mm_b", mm_b, exp_b);
    wait_done(400);
    chk("lat_228", MW'(cyc - acc_cyc), MW'(228));
    chk("done1", MW'(host.done), MW'(1));
    chk("err1", MW'(host.err), MW'(0));
    chk("ready_with_done", MW'(host.ready), MW'(1));
    chk("inverse1", host.inverse, all5);
    chk("cap_mm_a_clr", mm_a, '0);
    chk("cap_count", MW'(count), MW'(0));
    tick();
    chk("done_pulse_end", MW'(host.done), MW'(0));

    // stall of 10 cycles at count 100, then deferred done
    accept();
    repeat (100) tick();
    chk("stall_pre", MW'(count), MW'(100));
    host.en = 1'b0;
    repeat (10) tick();
    chk("stall_count", MW'(count), MW'(100));
    chk("stall_ready", MW'(host.ready), MW'(0));
    host.en = 1'b1;
    wait_done(400);
    chk("lat_238", MW'(cyc - acc_cyc), MW'(238));
    host.en = 1'b0;
    #1;
    chk("defer_done0", MW'(host.done), MW'(0));
    tick();
    chk("defer_done1", MW'(host.done), MW'(0));
    chk("defer_ready", MW'(host.ready), MW'(1));
    host.en = 1'b1;
    #1;
    chk("defer_release", MW'(host.done), MW'(1));
    tick();
    chk("defer_end", MW'(host.done), MW'(0));

    // start held: ignored while busy, second accept in the done cycle
    host.start = 1'b1;
    tick();
    acc_cyc = cyc;
    repeat (50) tick();
    host.matrix = m2;
    tick();
    chk("busy_ready", MW'(host.ready), MW'(0));
    chk("busy_count", MW'(count), MW'(51));
    chk("busy_matrix_q", matrix_q, m1);
    wait_done(400);
    chk("b2b_lat1", MW'(cyc - acc_cyc), MW'(228));
    tick();
    acc_cyc = cyc;
    chk("b2b_acc_ready", MW'(host.ready), MW'(0));
    chk("b2b_acc_count", MW'(count), MW'(0));
    chk("b2b_matrix_q", matrix_q, m2);
    wait_done(400);
    chk("b2b_lat2", MW'(cyc - acc_cyc), MW'(228));
    host.start = 1'b0;
    tick();
    chk("b2b_idle", MW'(host.ready), MW'(1));

    // reset mid-operation at count 150
    accept();
    repeat (150) tick();
    chk("rst150_pre", MW'(count), MW'(150));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst150_count", MW'(count), MW'(0));
    chk("rst150_ready", MW'(host.ready), MW'(1));
    chk("rst150_done", MW'(host.done), MW'(0));
    chk("rst150_matrix_q", matrix_q, '0);
    seen = 0;
    repeat (300) begin
      tick();
      if (host.done === 1'b1) seen++;
    end
    chk("rst150_no_done", MW'(seen), MW'(0));

    // fresh run with result stub all 9
    mm_res = all9;
    accept();
    wait_done(400);
    chk("lat_run9", MW'(cyc - acc_cyc), MW'(228));
    chk("inverse9", host.inverse, all9);
    tick();

    // zero on the Cholesky diagonal at [3][3]
    lt[(3*N+3)*W +: W] = '0;
    mm_res = all5;
    accept();
    repeat (108) tick();
    chk("sing_count", MW'(count), MW'(108));
    chk("sing_pre_done", MW'(host.done), MW'(0));
    tick();
`ifdef INVERSE_SINGULAR_CHECK_EN
    chk("sing_done", MW'(host.done), MW'(1));
    chk("sing_err", MW'(host.err), MW'(1));
    chk("sing_ready", MW'(host.ready), MW'(1));
    chk("sing_count0", MW'(count), MW'(0));
    chk("sing_inverse", host.inverse, all9);
    chk("sing_mm_a", mm_a, '0);
`else
    chk("nosing_done", MW'(host.done), MW'(0));
    chk("nosing_err", MW'(host.err), MW'(0));
    chk("nosing_count", MW'(count), MW'(109));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
